// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan path: FSM states, RGB565 field
// offsets, default panel geometry and per-plane bit extraction.
package hub75_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_e;

  localparam int R_OFS           = 11;
  localparam int G_OFS           = 6;   // green LSB (bit 5) is dropped
  localparam int B_OFS           = 0;
  localparam int PANEL_COLS      = 64;
  localparam int PANEL_ROW_PAIRS = 16;

  function automatic logic [2:0] plane_bits(input logic [15:0] pixel, input int p);
    logic [15:0] sh;
    sh = pixel >> p;
    return {sh[R_OFS], sh[G_OFS], sh[B_OFS]};
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// BCM display timer: loads BASE_TICKS<<plane on start, counts down and flags
// the final display cycle.
module hub75_bcm_timer #(
  parameter int BASE_TICKS = 32,
  parameter int PLANES     = 5,
  parameter int PLANE_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PLANE_W-1:0] plane,
  output logic               done
);

  localparam int CW = $clog2(BASE_TICKS << (PLANES - 1)) + 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)              count <= '0;
    else if (start)         count <= CW'(BASE_TICKS) << plane;
    else if (count != '0)   count <= count - CW'(1);
  end

  assign done = (count == CW'(1));

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: walks rows and BCM planes, prefetches pixels from the
// framebuffer, shifts them to the panel and owns the frame-aligned buffer swap.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS       = PANEL_COLS,
  parameter int ROW_PAIRS  = PANEL_ROW_PAIRS,
  parameter int PLANES     = 5,
  parameter int BASE_TICKS = 32,
  localparam int COL_W     = $clog2(COLS),
  localparam int ROW_W     = $clog2(ROW_PAIRS),
  localparam int PLANE_W   = $clog2(PLANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   frame_done,
  output logic                   buffer_toggle,
  output logic                   read_en,
  output logic [ROW_W+COL_W-1:0] read_addr,
  input  logic [15:0]            read_data_top,
  input  logic [15:0]            read_data_bottom,
  output logic                   hub75_clk,
  output logic                   hub75_latch,
  output logic                   hub75_oe_n,
  output logic [ROW_W-1:0]       hub75_addr,
  output logic [2:0]             hub75_rgb_top,
  output logic [2:0]             hub75_rgb_bottom
);

  // cnt spans PREFETCH (0..1) and SHIFT (2..2*COLS+1); SHIFT index is cnt-2
  localparam int CNT_W = $clog2(2 * COLS + 2);

  scan_state_e        state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ROW_W-1:0]   row, row_n;
  logic [PLANE_W-1:0] plane, plane_n;
  logic               pending, boundary, timer_done;
  logic               fetching_n, load_rgb, do_swap;

  hub75_bcm_timer #(
    .BASE_TICKS(BASE_TICKS),
    .PLANES    (PLANES),
    .PLANE_W   (PLANE_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .start(state == ST_LATCH),
    .plane(plane),
    .done (timer_done)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    row_n    = row;
    plane_n  = plane;
    boundary = 1'b0;
    unique case (state)
      ST_IDLE: if (enable) begin
        state_n = ST_PREFETCH;
        cnt_n   = '0;
      end
      ST_PREFETCH: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(2 * COLS + 1)) state_n = ST_LATCH;
        else                             cnt_n   = cnt + CNT_W'(1);
      end
      ST_LATCH: state_n = ST_DISPLAY;
      ST_DISPLAY: if (timer_done) begin
        state_n = ST_PREFETCH;
        cnt_n   = '0;
        if (plane != PLANE_W'(PLANES - 1)) begin
          plane_n = plane + PLANE_W'(1);
        end else begin
          plane_n = '0;
          if (row != ROW_W'(ROW_PAIRS - 1)) begin
            row_n = row + ROW_W'(1);
          end else begin
            row_n    = '0;
            boundary = 1'b1;
            if (!enable) state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign fetching_n = (state_n == ST_PREFETCH) || (state_n == ST_SHIFT);
  // RAM data for column c arrives on odd cnt, one cycle before it is shifted
  assign load_rgb   = ((state == ST_PREFETCH) || (state == ST_SHIFT)) && cnt[0] &&
                      (cnt < CNT_W'(2 * COLS));
  assign do_swap    = boundary && (pending || swap_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      row              <= '0;
      plane            <= '0;
      pending          <= 1'b0;
      buffer_toggle    <= 1'b0;
      frame_done       <= 1'b0;
      swap_ack         <= 1'b0;
      read_en          <= 1'b0;
      read_addr        <= '0;
      hub75_clk        <= 1'b0;
      hub75_latch      <= 1'b0;
      hub75_oe_n       <= 1'b1;
      hub75_addr       <= '0;
      hub75_rgb_top    <= '0;
      hub75_rgb_bottom <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      row         <= row_n;
      plane       <= plane_n;
      pending     <= (pending || swap_req) && !boundary;
      frame_done  <= boundary;
      swap_ack    <= do_swap;
      if (do_swap) buffer_toggle <= ~buffer_toggle;
      read_en     <= fetching_n;
      if (fetching_n) read_addr <= {row_n, cnt_n[COL_W:1]};
      hub75_clk   <= (state_n == ST_SHIFT) && cnt_n[0];
      hub75_latch <= (state_n == ST_LATCH);
      hub75_oe_n  <= (state_n != ST_DISPLAY);
      if (state_n == ST_LATCH) hub75_addr <= row;
      if (load_rgb) begin
        hub75_rgb_top    <= plane_bits(read_data_top, int'(plane));
        hub75_rgb_bottom <= plane_bits(read_data_bottom, int'(plane));
      end
    end
  end

endmodule
